fsm_moore_seqdet: RTL and testbench



---
 rtl/fsm_moore_seqdet.sv | 116 +++++++++++
 tb/tb_fsm_moore_seqdet.sv | 117 +++++++++++
 2 files changed

// File: rtl/fsm_moore_seqdet.sv
// Parametrised Moore sequence detector with run-time overlap selection and a
// saturating match counter. The transition table is built once at elaboration.
module fsm_moore_seqdet #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CNT_W   = 8,
    parameter int             SW      = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             en,
    input  logic             ovl,
    input  logic             clr_cnt,
    output logic             Z,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    if (N < 1 || N > 16 || CNT_W < 1) begin : g_bad_params
        $error("fsm_moore_seqdet: need 1 <= N <= 16 and CNT_W >= 1");
    end

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [N-1:0] t;
        t = PATTERN >> (N - 1 - i);
        return t[0];
    endfunction

    // Longest proper border of the pattern.
    function automatic int border_len();
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < N; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (pat_bit(j) != pat_bit(N - k + j)) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest suffix of (first b pattern bits, xb) that is a pattern prefix.
    function automatic int next_len(input int b, input logic xb);
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k <= N; k++) begin
            if (k <= b + 1) begin
                ok = (xb == pat_bit(k - 1));
                for (int j = 0; j < k - 1; j++)
                    if (pat_bit(b - k + 1 + j) != pat_bit(j)) ok = 1'b0;
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    localparam int            B     = border_len();
    localparam int            TBL_D = 2 ** SW;
    localparam logic [SW-1:0] S_N   = SW'(N);
    localparam logic [SW-1:0] S_B   = SW'(B);

    // Indexed by base state; entries at and above N are never selected.
    logic [SW-1:0] nxt_tbl [TBL_D][2];

    for (genvar g = 0; g < TBL_D; g++) begin : g_tbl
        if (g < N) begin : g_live
            assign nxt_tbl[g][0] = SW'(next_len(g, 1'b0));
            assign nxt_tbl[g][1] = SW'(next_len(g, 1'b1));
        end else begin : g_pad
            assign nxt_tbl[g][0] = '0;
            assign nxt_tbl[g][1] = '0;
        end
    end

    logic [SW-1:0]    state_q, state_d, base;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        base    = state_q;
        state_d = state_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        // ovl only matters on the edge that leaves SN.
        if (state_q == S_N) base = ovl ? S_B : '0;
        if (en) begin
            state_d = nxt_tbl[base][x];
            z_d     = (state_d == S_N);
        end
        if (clr_cnt)
            cnt_d = '0;
        else if (en && state_d == S_N && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign Z         = z_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_moore_seqdet.sv
// Directed bench: default detector (1011, 8-bit counter) alongside a
// 2-bit-counter copy driven by the same stimulus.
module tb_fsm_moore_seqdet;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0, en = 1'b0, ovl = 1'b0, clr_cnt = 1'b0;
    logic       z_a, z_b;
    logic [2:0] st_a, st_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_chk = 0;
    int n_pass = 0;

    fsm_moore_seqdet dut (
        .clk(clk), .rst(rst), .x(x), .en(en), .ovl(ovl), .clr_cnt(clr_cnt),
        .Z(z_a), .state(st_a), .match_cnt(cnt_a)
    );

    fsm_moore_seqdet #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x(x), .en(en), .ovl(ovl), .clr_cnt(clr_cnt),
        .Z(z_b), .state(st_b), .match_cnt(cnt_b)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic x, en, ovl, clr;
        int   st;
        logic z;
        int   cnt, cnt2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int st, input logic z,
                           input int c, input int c2);
        chk({tag, " state"},  int'(st_a),  st);
        chk({tag, " Z"},      int'(z_a),   int'(z));
        chk({tag, " cnt"},    int'(cnt_a), c);
        chk({tag, " state2"}, int'(st_b),  st);
        chk({tag, " Z2"},     int'(z_b),   int'(z));
        chk({tag, " cnt2"},   int'(cnt_b), c2);
    endtask

    task automatic add(input logic xi, input logic e, input logic o, input logic c,
                       input int st, input logic z, input int cn, input int cn2);
        vq.push_back('{xi, e, o, c, st, z, cn, cn2});
    endtask

    task automatic step(input logic xi, input logic e, input logic o, input logic c);
        @(negedge clk);
        #2;
        x = xi; en = e; ovl = o; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en=0 with toggling x: everything holds at reset values
        for (int i = 0; i < 5; i++) add(i[0], 0, 1, 0, 0, 0, 0, 0);
        // 1011011, overlapping
        add(1,1,1,0, 1,0,0,0); add(0,1,1,0, 2,0,0,0); add(1,1,1,0, 3,0,0,0);
        add(1,1,1,0, 4,1,1,1); add(0,1,1,0, 2,0,1,1); add(1,1,1,0, 3,0,1,1);
        add(1,1,1,0, 4,1,2,2);
        // en=0 keeps Z high; clear still acts
        add(0,0,1,1, 4,1,0,0);
        // 1011011, non-overlapping
        add(1,1,0,0, 1,0,0,0); add(0,1,0,0, 2,0,0,0); add(1,1,0,0, 3,0,0,0);
        add(1,1,0,0, 4,1,1,1); add(0,1,0,0, 0,0,1,1); add(1,1,0,0, 1,0,1,1);
        add(1,1,0,0, 1,0,1,1);
        // back to S0, then failure fallback 101011
        add(0,1,0,0, 2,0,1,1); add(0,1,0,0, 0,0,1,1);
        add(1,1,0,0, 1,0,1,1); add(0,1,0,0, 2,0,1,1); add(1,1,0,0, 3,0,1,1);
        add(0,1,0,0, 2,0,1,1); add(1,1,0,0, 3,0,1,1); add(1,1,0,0, 4,1,2,2);
        add(0,0,0,1, 4,1,0,0);
        // five overlapped detections; ovl flips off mid-pattern with no effect
        for (int d = 1; d <= 5; d++) begin
            add(0,1,1,0, 2,0,d-1,(d-1 > 3) ? 3 : d-1);
            add(1,1,0,0, 3,0,d-1,(d-1 > 3) ? 3 : d-1);
            add(1,1,0,0, 4,1,d,  (d > 3) ? 3 : d);
        end
        // sixth detection collides with clear: clear wins
        add(0,1,1,0, 2,0,5,3); add(1,1,0,0, 3,0,5,3); add(1,1,0,1, 4,1,0,0);

        #50;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].x, vq[i].en, vq[i].ovl, vq[i].clr);
            chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].z, vq[i].cnt, vq[i].cnt2);
        end

        // async reset mid-pattern
        step(1,1,0,0); step(0,1,0,0); step(1,1,0,0);
        chk_all("pre-rst", 3, 0, 0, 0);
        #5 rst = 1'b1;
        #1 chk_all("async rst", 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        step(1,1,0,0);
        chk_all("after rst", 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
